// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the host byte link and the IMEM write port.
//   byte_in    [7:0]            stream data byte from the host
//   byte_valid                  byte_in is valid
//   byte_ready                  loader can accept a byte this cycle
//   imem_we                     IMEM write strobe, one cycle per word
//   imem_addr  [ADDR_WIDTH-1:0] IMEM word address
//   imem_wdata [31:0]           IMEM write data
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both 1; byte_in is ignored on every other cycle. byte_ready
// does not depend on byte_valid, and the host may hold byte_valid high for
// as long as it has a byte to offer.
// Modports: master = host/bench side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte stream,
// assembles 32-bit little-endian words and writes them into IMEM, holding
// the core in reset until the whole image has been written and verified.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_start         one-cycle pulse to begin a load (IDLE/DONE/ERR only)
//   bus             imem_loader_if.slave: byte link in, IMEM write port out
//   o_cpu_hold      reset request to the core (low only in DONE)
//   o_done          image loaded and checksum correct
//   o_error         length or checksum failure
//   o_word_count    words written in the current load
//   o_state         current FSM state, for debug/observation
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  imem_loader_if.slave       bus,
  output logic               o_cpu_hold,
  output logic               o_done,
  output logic               o_error,
  output logic [15:0]        o_word_count,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_len;
  logic [15:0]           r_word_count;
  logic [7:0]            r_csum;
  logic [1:0]            r_idx;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_start_ok;
  logic [15:0]           w_len_full;
  logic [15:0]           w_count_inc;
  logic [31:0]           w_word_next;

  assign w_accept    = bus.byte_valid && w_ready;
  assign w_start_ok  = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  // Full length as it will be once the LEN_HI byte lands.
  assign w_len_full  = {bus.byte_in, r_len[7:0]};
  assign w_count_inc = r_word_count + 16'd1;

  // Current word with the incoming byte placed in its lane.
  always_comb begin
    w_word_next = r_word;
    w_word_next[8*r_idx +: 8] = bus.byte_in;
  end

  // Next-state and handshake logic.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_start_ok) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_ready = 1'b1;
        if (w_accept) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_ready = 1'b1;
        if (w_accept) begin
          if (w_len_full == 16'd0)               w_next = S_CHECK;
          else if (int'(w_len_full) > MAX_WORDS) w_next = S_ERR;
          else                                   w_next = S_DATA;
        end
      end
      S_DATA: begin
        w_ready = 1'b1;
        if (w_accept && r_idx == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = (w_count_inc == r_len) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        w_ready = 1'b1;
        if (w_accept) w_next = (bus.byte_in == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_word_count <= '0;
      r_csum       <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_word_count <= '0;
        r_csum       <= '0;
        r_idx        <= '0;
        r_word       <= '0;
      end
      if (r_state == S_LEN_LO && w_accept) r_len[7:0]  <= bus.byte_in;
      if (r_state == S_LEN_HI && w_accept) r_len[15:8] <= bus.byte_in;
      if (r_state == S_DATA && w_accept) begin
        r_word <= w_word_next;
        r_csum <= r_csum ^ bus.byte_in;
        r_idx  <= r_idx + 2'd1;
        // Stage the write port on the 4th byte so address and data are
        // already presented during the WRITE cycle, then held afterwards.
        if (r_idx == 2'd3) begin
          r_addr  <= r_word_count[ADDR_WIDTH-1:0];
          r_wdata <= w_word_next;
        end
      end
      if (r_state == S_WRITE) r_word_count <= w_count_inc;
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.imem_we    = (r_state == S_WRITE);
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign o_cpu_hold     = (r_state != S_DONE);
  assign o_done         = (r_state == S_DONE);
  assign o_error        = (r_state == S_ERR);
  assign o_word_count   = r_word_count;
  assign o_state        = r_state;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int AW = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd7;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_word_count;
  logic [2:0]  o_state;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .bus          (bus),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count),
    .o_state      (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard ----------------
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] got_q[$];
  logic [7:0]     tx_q[$];
  int             stall_cnt;
  int             we_ready_cnt;

  always @(negedge clk) begin
    if (bus.imem_we) got_q.push_back({bus.imem_addr, bus.imem_wdata});
    if (bus.imem_we && bus.byte_ready) we_ready_cnt++;
    if (bus.byte_valid && !bus.byte_ready) stall_cnt++;
  end

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwrites"}, 40'(got_q.size()), 40'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_write"}, 40'(got_q.pop_front()), 40'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Offer one byte and return #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    while (!bus.byte_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.byte_ready) begin
      chk("ready_timeout", 40'(bus.byte_ready), 40'd1);
      bus.byte_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; i_start = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
    stall_cnt = 0; we_ready_cnt = 0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    chk("rst_cpu_hold", 40'(o_cpu_hold), 40'd1);
    chk("rst_ready",    40'(bus.byte_ready), 40'd0);
    chk("rst_we",       40'(bus.imem_we), 40'd0);
    chk("rst_addr",     40'(bus.imem_addr), 40'd0);
    chk("rst_wdata",    40'(bus.imem_wdata), 40'd0);
    chk("rst_done",     40'(o_done), 40'd0);
    chk("rst_error",    40'(o_error), 40'd0);
    chk("rst_wc",       40'(o_word_count), 40'd0);
    chk("rst_state",    40'(o_state), 40'(ST_IDLE));

    // 1: single word 0x00500513, checksum 0x46, with latency checks
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h50};
    send_q();
    send_byte(8'h00);
    chk("t1_we_latency", 40'(bus.imem_we), 40'd1);
    chk("t1_bubble",     40'(bus.byte_ready), 40'd0);
    chk("t1_addr",       40'(bus.imem_addr), 40'h0);
    chk("t1_wdata",      40'(bus.imem_wdata), 40'h00500513);
    idle_cycles(1);
    chk("t1_ready_back", 40'(bus.byte_ready), 40'd1);
    chk("t1_we_off",     40'(bus.imem_we), 40'd0);
    send_byte(8'h46);
    chk("t1_done",     40'(o_done), 40'd1);
    chk("t1_cpu_hold", 40'(o_cpu_hold), 40'd0);
    chk("t1_error",    40'(o_error), 40'd0);
    chk("t1_wc",       40'(o_word_count), 40'd1);
    exp_q.push_back({8'd0, 32'h00500513});
    compare_writes("t1");

    // 2: three words, correct checksum 0x82, back-to-back bytes
    pulse_start();
    chk("t2_done_cleared", 40'(o_done), 40'd0);
    stall_cnt = 0; we_ready_cnt = 0;
    tx_q = '{8'h03, 8'h00,
             8'h93, 8'h00, 8'h00, 8'h00,
             8'h13, 8'h01, 8'h10, 8'h00,
             8'hE3, 8'h0E, 8'h00, 8'hFE,
             8'h82};
    send_q();
    chk("t2_stalls",   40'(stall_cnt), 40'd3);
    chk("t2_we_ready", 40'(we_ready_cnt), 40'd0);
    chk("t2_done",     40'(o_done), 40'd1);
    chk("t2_wc",       40'(o_word_count), 40'd3);
    exp_q.push_back({8'd0, 32'h00000093});
    exp_q.push_back({8'd1, 32'h00100113});
    exp_q.push_back({8'd2, 32'hFE000EE3});
    compare_writes("t2");

    // 3: same stream, wrong checksum
    pulse_start();
    tx_q = '{8'h03, 8'h00,
             8'h93, 8'h00, 8'h00, 8'h00,
             8'h13, 8'h01, 8'h10, 8'h00,
             8'hE3, 8'h0E, 8'h00, 8'hFE,
             8'h83};
    send_q();
    chk("t3_done",     40'(o_done), 40'd0);
    chk("t3_error",    40'(o_error), 40'd1);
    chk("t3_cpu_hold", 40'(o_cpu_hold), 40'd1);
    exp_q.push_back({8'd0, 32'h00000093});
    exp_q.push_back({8'd1, 32'h00100113});
    exp_q.push_back({8'd2, 32'hFE000EE3});
    compare_writes("t3");

    // 4: N=257 exceeds limit, ERR straight after LEN_HI
    pulse_start();
    chk("t4_err_cleared", 40'(o_error), 40'd0);
    tx_q = '{8'h01, 8'h01};
    send_q();
    chk("t4_error", 40'(o_error), 40'd1);
    chk("t4_state", 40'(o_state), 40'(ST_ERR));
    chk("t4_ready", 40'(bus.byte_ready), 40'd0);
    idle_cycles(5);
    chk("t4_cpu_hold", 40'(o_cpu_hold), 40'd1);
    compare_writes("t4");

    // 5a: N=0, checksum 00 -> DONE
    pulse_start();
    tx_q = '{8'h00, 8'h00, 8'h00};
    send_q();
    chk("t5a_done", 40'(o_done), 40'd1);
    chk("t5a_wc",   40'(o_word_count), 40'd0);
    // 5b: N=0, checksum 5A -> ERR
    pulse_start();
    tx_q = '{8'h00, 8'h00, 8'h5A};
    send_q();
    chk("t5b_error", 40'(o_error), 40'd1);
    chk("t5b_done",  40'(o_done), 40'd0);
    compare_writes("t5");

    // 6: abort mid-word with rst, ignored start during DATA, then clean load
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_q();
    pulse_start();
    chk("t6_start_ignored", 40'(o_state), 40'(ST_DATA));
    chk("t6_ready_data",    40'(bus.byte_ready), 40'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rst_state", 40'(o_state), 40'(ST_IDLE));
    chk("t6_rst_addr",  40'(bus.imem_addr), 40'd0);
    chk("t6_rst_wdata", 40'(bus.imem_wdata), 40'd0);
    chk("t6_rst_hold",  40'(o_cpu_hold), 40'd1);
    chk("t6_rst_error", 40'(o_error), 40'd0);
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h25};
    send_q();
    chk("t6_done", 40'(o_done), 40'd1);
    chk("t6_wc",   40'(o_word_count), 40'd1);
    exp_q.push_back({8'd0, 32'h00001237});
    compare_writes("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction path: receives a byte stream from the debug/boot host, assembles 32-bit instruction words and writes them into instruction memory.
- Holds the core in reset until the full image is written and checksummed; the core's fetch and decode logic then reads what this block wrote.
- Sits between the host byte link and the IMEM write port, beside the single-cycle core.

Parameters:
- ADDR_WIDTH, 8, word-address width of IMEM.
- MAX_WORDS, 256, largest accepted image in words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse to begin a load; honoured only in IDLE, DONE or ERR.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  block can accept a byte this cycle.
- imem_we  output  1  IMEM write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  IMEM word address.
- imem_wdata  output  32  IMEM write data.
- cpu_hold  output  1  active-high reset request to the core.
- done  output  1  image loaded and checksum correct.
- error  output  1  length or checksum failure.
- word_count  output  16  words written in the current load.

Behaviour:
- Transfer rule: a byte is accepted only on a cycle where byte_valid and byte_ready are both 1. byte_in is ignored on all other cycles.
- Stream format:
  - LEN_LO, then LEN_HI: 16-bit word count N.
  - Then 4N payload bytes, least-significant byte first within each word.
  - Then one checksum byte, equal to the XOR of all 4N payload bytes. Length bytes are excluded from the checksum.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR.
- Reset values: state IDLE; cpu_hold=1; byte_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; done=0; error=0; word_count=0; checksum accumulator=0; byte index=0.
- IDLE: byte_ready=0. On start: go to LEN_LO, clear word_count, checksum and byte index, set cpu_hold=1.
- LEN_LO and LEN_HI: byte_ready=1. One accepted byte each.
- After LEN_HI is accepted, the next state depends on N:
  - N=0: go to CHECK. The expected checksum is 0.
  - N>MAX_WORDS: go to ERR. The payload is not consumed.
  - Otherwise: go to DATA.
- DATA: byte_ready=1.
  - Each accepted byte shifts into the word at lane = byte index and is XORed into the checksum. The byte index is 2 bits and wraps 3→0.
  - On the 4th byte, go to WRITE.
- WRITE: exactly one cycle.
  - imem_we=1, imem_addr=word_count[ADDR_WIDTH-1:0], imem_wdata=assembled word. byte_ready=0 (one-cycle bubble).
  - word_count increments at the end of this cycle.
  - Next state is CHECK if the new word_count equals N, else DATA.
- imem_we is 0 in every state other than WRITE. imem_addr and imem_wdata hold their last values.
- CHECK: byte_ready=1. On the accepted byte:
  - Byte equals the accumulator: go to DONE.
  - Otherwise: go to ERR.
- DONE: done=1, cpu_hold=0, byte_ready=0.
- ERR: error=1, cpu_hold=1, byte_ready=0.
- Exit from DONE or ERR: start clears done and error on the following cycle and enters LEN_LO.
- start is ignored in LEN_LO, LEN_HI, DATA, WRITE and CHECK. A load cannot be aborted except by rst.
- rst mid-load: returns every output to its reset value next cycle. Words already written to IMEM are not erased.
- byte_valid held low stalls indefinitely in any receiving state; there is no timeout.
- Latency: the last payload byte is accepted in cycle t. imem_we=1 in t+1; byte_ready returns to 1 in t+2.

Test Plan:
- rst, start, stream 01 00 13 05 50 00 then checksum 0x46 → one imem_we with addr 0, wdata 0x00500513; done=1, cpu_hold=0, word_count=1.
- N=3 with words 0x00000093, 0x00100113, 0xFE000EE3 and the correct checksum → writes to addr 0,1,2 in order. byte_ready is 0 exactly on each WRITE cycle.
- Same stream with a wrong checksum byte → no done; error=1, cpu_hold stays 1; the words are still written.
- Length bytes 01 01 (N=257 > 256) → ERR immediately after LEN_HI; no imem_we pulse.
- Length 00 00 then checksum 00 → DONE with word_count=0. Length 00 00 then checksum 5A → ERR.
- rst asserted after 2 of 4 data bytes, then a new start and a full 1-word load → clean load to addr 0, with no lanes carried over from the aborted word. A start pulse issued during DATA has no effect.
